// File: rtl/ifetch_unit.sv
// Instruction fetch unit: drives the ROM address, buffers {pc, instr} pairs in a small
// prefetch FIFO and hands them to decode. Optional fetch halt via macro IFETCH_HALT_EN.
module ifetch_unit #(
    parameter int             n         = 16,
    parameter int             r         = 5,
    parameter int             DEPTH     = 2,
    parameter logic [r-1:0]   RESET_PC  = '0,
    parameter logic [n-1:0]   HALT_WORD = {n{1'b1}}
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [r-1:0]             pc,
    input  logic [n-1:0]             instr,
    input  logic                     redirect,
    input  logic [r-1:0]             redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [n-1:0]             out_instr,
    output logic [r-1:0]             out_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     halted
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [n-1:0]  mem_instr [DEPTH];
    logic [r-1:0]  mem_pc    [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          pop;
    logic          fetch;
    logic          halt_hit;

    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    // Gate storage with valid so the outputs read zero (never stale or X) while empty.
    assign out_instr = out_valid ? mem_instr[head] : '0;
    assign out_pc    = out_valid ? mem_pc[head]    : '0;

`ifdef IFETCH_HALT_EN
    typedef enum logic {FETCH, HALTED} state_t;
    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (redirect)      state_nxt = FETCH;
        else if (halt_hit) state_nxt = HALTED;
    end

    assign fetch    = (state == FETCH) && !redirect && ((count < FULL) || pop);
    assign halt_hit = fetch && (instr == HALT_WORD);
    assign halted   = (state == HALTED);
`else
    assign fetch    = !redirect && ((count < FULL) || pop);
    assign halt_hit = 1'b0;
    // Reference HALT_WORD so the parameter list is identical in both builds.
    assign halted   = 1'b0 & (|HALT_WORD);
`endif

    // Control: pc, pointers and occupancy; redirect overrides fetch and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect) begin
            pc    <= redirect_pc;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop)               head <= head + AW'(1);
            if (fetch)             tail <= tail + AW'(1);
            if (fetch && !halt_hit) pc  <= pc + r'(1);
            count <= count + (AW+1)'(fetch) - (AW+1)'(pop);
        end
    end

    // Data storage carries no reset; out_valid qualifies it.
    always_ff @(posedge clk) begin
        if (fetch) begin
            mem_instr[tail] <= instr;
            mem_pc[tail]    <= pc;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus random traffic checked against a
// queue-based model of the fetch buffer.
module tb_ifetch_unit;

    localparam int N = 16;
    localparam int R = 5;
    localparam int DEPTH = 2;
    localparam logic [N-1:0] HALTW = 16'hFFFF;

    typedef struct packed {
        logic [R-1:0] p;
        logic [N-1:0] i;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [R-1:0]  pc;
    logic [N-1:0]  instr;
    logic          redirect;
    logic [R-1:0]  redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_instr;
    logic [R-1:0]  out_pc;
    logic [1:0]    count;
    logic          halted;

    logic [N-1:0]  rom [32];
    ent_t          q[$];
    logic [R-1:0]  mpc;
    bit            mhalt;
    int            total = 0;
    int            bad = 0;

    assign instr = rom[pc];

    ifetch_unit #(.n(N), .r(R), .DEPTH(DEPTH), .RESET_PC('0), .HALT_WORD(HALTW)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .instr(instr),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .count(count), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mpc   = '0;
        mhalt = 0;
    endtask

    task automatic check_model(input string tag);
        ent_t h;
        h = (q.size() > 0) ? q[0] : '0;
        chk({tag, ".valid"},  32'(out_valid), 32'(q.size() > 0));
        chk({tag, ".count"},  32'(count),     32'(q.size()));
        chk({tag, ".pc"},     32'(pc),        32'(mpc));
        chk({tag, ".halted"}, 32'(halted),    32'(mhalt));
        chk({tag, ".opc"},    32'(out_pc),    32'(h.p));
        chk({tag, ".oinstr"}, 32'(out_instr), 32'(h.i));
    endtask

    // Drive inputs after a falling edge, advance one rising edge, check at the next falling edge.
    task automatic step(input string tag, input logic rd, input logic [R-1:0] rpc, input logic rdy);
        ent_t e;
        bit   pop;
        redirect    = rd;
        redirect_pc = rpc;
        out_ready   = rdy;
        pop = (q.size() > 0) && rdy;
        if (rd) begin
            q.delete();
            mpc   = rpc;
            mhalt = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (!mhalt && q.size() < DEPTH) begin
                e.p = mpc;
                e.i = rom[mpc];
                q.push_back(e);
`ifdef IFETCH_HALT_EN
                if (e.i == HALTW) mhalt = 1;
                else              mpc = mpc + 5'd1;
`else
                mpc = mpc + 5'd1;
`endif
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_model(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rom[i] = 16'($urandom);
            if (rom[i] == HALTW) rom[i] = 16'hFFFE;
        end
        rom[0] = 16'h00A1; rom[1] = 16'h00B2; rom[2] = 16'h00C3; rom[3] = 16'h00D4;
        model_reset();
        #12;
        check_model("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming from reset.
        step("s0", 0, 0, 1);
        chk("s0_pc_exp", 32'(out_pc), 0);
        chk("s0_instr_exp", 32'(out_instr), 32'h00A1);
        step("s1", 0, 0, 1);
        chk("s1_instr_exp", 32'(out_instr), 32'h00B2);
        step("s2", 0, 0, 1);
        step("s3", 0, 0, 1);
        chk("s3_instr_exp", 32'(out_instr), 32'h00D4);
        chk("s3_count_exp", 32'(count), 1);

        // Backpressure after restarting at 0.
        step("bp_rd", 1, 0, 0);
        for (int i = 0; i < 5; i++) step("bp", 0, 0, 0);
        chk("bp_count", 32'(count), 2);
        chk("bp_pc", 32'(pc), 2);
        chk("bp_head_pc", 32'(out_pc), 0);
        chk("bp_head_instr", 32'(out_instr), 32'h00A1);
        step("bp_go0", 0, 0, 1);
        chk("bp_go0_pc", 32'(out_pc), 1);
        step("bp_go1", 0, 0, 1);
        chk("bp_go1_pc", 32'(out_pc), 2);

        // pc wrap.
        step("wr_rd", 1, 31, 1);
        chk("wr_rd_valid", 32'(out_valid), 0);
        step("wr0", 0, 0, 1);
        chk("wr0_pc", 32'(out_pc), 31);
        step("wr1", 0, 0, 1);
        chk("wr1_pc", 32'(out_pc), 0);
        step("wr2", 0, 0, 1);
        chk("wr2_pc", 32'(out_pc), 1);

        // Redirect while full.
        step("fl0", 0, 0, 0);
        step("fl1", 0, 0, 0);
        chk("fl_full", 32'(count), 2);
        step("fl_rd", 1, 7, 1);
        chk("fl_rd_valid", 32'(out_valid), 0);
        chk("fl_rd_pc", 32'(pc), 7);
        step("fl_a", 0, 0, 1);
        chk("fl_a_pc", 32'(out_pc), 7);
        step("fl_b", 0, 0, 1);
        chk("fl_b_pc", 32'(out_pc), 8);

        // Asynchronous reset between edges.
        step("ar_pre", 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("ar_valid", 32'(out_valid), 0);
        chk("ar_count", 32'(count), 0);
        chk("ar_pc", 32'(pc), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step("ar_s0", 0, 0, 1);
        chk("ar_s0_pc", 32'(out_pc), 0);

        // Random traffic.
        for (int i = 0; i < 300; i++)
            step("rnd", ($urandom_range(0, 9) == 0), R'($urandom), 1'($urandom));

`ifdef IFETCH_HALT_EN
        rom[2] = HALTW;
        step("h_rd", 1, 0, 1);
        for (int i = 0; i < 3; i++) step("h_run", 0, 0, 1);
        chk("h_halted", 32'(halted), 1);
        chk("h_pc", 32'(pc), 2);
        chk("h_last", 32'(out_pc), 2);
        step("h_drain", 0, 0, 1);
        chk("h_empty", 32'(out_valid), 0);
        step("h_idle", 0, 0, 1);
        step("h_res", 1, 0, 1);
        chk("h_res_halted", 32'(halted), 0);
        step("h_res0", 0, 0, 1);
        chk("h_res0_pc", 32'(out_pc), 0);
        rom[2] = 16'h00C3;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
